// File: rtl/cpu_v9_pkg.sv
// Shared types and instruction-field layout for the cpu_v9 core.
// Field offsets are derived from the instruction and register-address widths.
package cpu_v9_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_MOV  = 4'd1,
        OP_LDI  = 4'd2,
        OP_IN   = 4'd3,
        OP_OUT  = 4'd4,
        OP_ADD  = 4'd5,
        OP_SUB  = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_XOR  = 4'd9,
        OP_JMP  = 4'd10,
        OP_JZ   = 4'd11,
        OP_JNZ  = 4'd12,
        OP_JC   = 4'd13,
        OP_RSV  = 4'd14,
        OP_HALT = 4'd15
    } opcode_t;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    // Fields pack downward from the MSB: op, rd, ra, rb.
    function automatic int op_lsb(int iw);
        return iw - OP_W;
    endfunction

    function automatic int rd_lsb(int iw, int raw);
        return iw - OP_W - raw;
    endfunction

    function automatic int ra_lsb(int iw, int raw);
        return iw - OP_W - 2 * raw;
    endfunction

    function automatic int rb_lsb(int iw, int raw);
        return iw - OP_W - 3 * raw;
    endfunction

endpackage

// File: rtl/cpu_v9_register_file.sv
// Register file: one synchronous write port, two combinational read ports,
// synchronous reset of every entry to zero.
module register_file_v2 #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [WIDTH-1:0]      rdata_a,
    output logic [WIDTH-1:0]      rdata_b
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0][WIDTH-1:0] regs;

    always_ff @(posedge clk) begin
        if (reset)
            regs <= '0;
        else if (we)
            regs[waddr] <= wdata;
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_v9.sv
// Single-issue register CPU with Z/C flags, conditional jumps, HALT and
// valid/ready input/output ports; program ROM is external and combinational.
module cpu_v9
    import cpu_v9_pkg::*;
#(
    parameter int BUS_WIDTH        = 8,
    parameter int REG_ADDR_WIDTH   = 3,
    parameter int INSTR_ADDR_WIDTH = 6,
    parameter int INSTR_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
    input  logic [INSTR_WIDTH-1:0]      instr,
    input  logic [BUS_WIDTH-1:0]        in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [BUS_WIDTH-1:0]        out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        halted
);
    localparam int OP_LSB = op_lsb(INSTR_WIDTH);
    localparam int RD_LSB = rd_lsb(INSTR_WIDTH, REG_ADDR_WIDTH);
    localparam int RA_LSB = ra_lsb(INSTR_WIDTH, REG_ADDR_WIDTH);
    localparam int RB_LSB = rb_lsb(INSTR_WIDTH, REG_ADDR_WIDTH);
    localparam logic [INSTR_ADDR_WIDTH-1:0] PC_ONE = 1;

    typedef struct packed {
        opcode_t                     op;
        logic [REG_ADDR_WIDTH-1:0]   rd;
        logic [REG_ADDR_WIDTH-1:0]   ra;
        logic [REG_ADDR_WIDTH-1:0]   rb;
        logic [BUS_WIDTH-1:0]        imm;
        logic [INSTR_ADDR_WIDTH-1:0] target;
    } dec_t;

    dec_t                        d;
    state_t                      state;
    logic [INSTR_ADDR_WIDTH-1:0] pc;
    logic                        z_flag, c_flag;
    logic [BUS_WIDTH-1:0]        ra_data, rb_data, wr_data, alu_res;
    logic                        alu_c, alu_op, we, run, out_load, stall, take_jump;

    always_comb begin
        d.op     = opcode_t'(instr[OP_LSB +: OP_W]);
        d.rd     = instr[RD_LSB +: REG_ADDR_WIDTH];
        d.ra     = instr[RA_LSB +: REG_ADDR_WIDTH];
        d.rb     = instr[RB_LSB +: REG_ADDR_WIDTH];
        d.imm    = instr[BUS_WIDTH-1:0];
        d.target = instr[INSTR_ADDR_WIDTH-1:0];
    end

    register_file_v2 #(.WIDTH(BUS_WIDTH), .ADDR_WIDTH(REG_ADDR_WIDTH)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (d.rd),
        .wdata   (wr_data),
        .raddr_a (d.ra),
        .raddr_b (d.rb),
        .rdata_a (ra_data),
        .rdata_b (rb_data)
    );

    assign run        = (state == ST_RUN);
    assign halted     = (state == ST_HALT);
    assign instr_addr = pc;
    assign in_ready   = run && (d.op == OP_IN);
    // OUT may reload in the same cycle the consumer drains the old value.
    assign out_load   = run && (d.op == OP_OUT) && (!out_valid || out_ready);
    assign stall      = ((d.op == OP_IN) && !in_valid) || ((d.op == OP_OUT) && !out_load);
    assign alu_op     = (d.op == OP_ADD) || (d.op == OP_SUB) || (d.op == OP_AND) ||
                        (d.op == OP_OR)  || (d.op == OP_XOR);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (d.op)
            OP_ADD: {alu_c, alu_res} = {1'b0, ra_data} + {1'b0, rb_data};
            OP_SUB: begin
                alu_res = ra_data - rb_data;
                alu_c   = (ra_data < rb_data);
            end
            OP_AND: alu_res = ra_data & rb_data;
            OP_OR:  alu_res = ra_data | rb_data;
            OP_XOR: alu_res = ra_data ^ rb_data;
            default: ;
        endcase
    end

    always_comb begin
        we      = 1'b0;
        wr_data = alu_res;
        case (d.op)
            OP_MOV: begin we = run; wr_data = ra_data; end
            OP_LDI: begin we = run; wr_data = d.imm;   end
            OP_IN:  begin we = in_ready && in_valid; wr_data = in_data; end
            default: we = run && alu_op;
        endcase
    end

    always_comb begin
        case (d.op)
            OP_JMP:  take_jump = 1'b1;
            OP_JZ:   take_jump = z_flag;
            OP_JNZ:  take_jump = !z_flag;
            OP_JC:   take_jump = c_flag;
            default: take_jump = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            pc        <= '0;
            z_flag    <= 1'b0;
            c_flag    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            // Output handshake keeps running in HALT so a pending value drains.
            if (out_load) begin
                out_data  <= ra_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (run) begin
                if (d.op == OP_HALT)
                    state <= ST_HALT;
                else if (!stall)
                    pc <= take_jump ? d.target : pc + PC_ONE;
                if (alu_op) begin
                    z_flag <= (alu_res == '0);
                    c_flag <= alu_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_v9.sv
// Self-checking bench for cpu_v9: directed flag/result vectors, hand-written
// handshake/reset sequences, and random programs checked against an ISA model.
module tb_cpu_v9;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  instr_addr;
    logic [15:0] instr;
    logic [7:0]  in_data;
    logic        in_valid, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_ready, halted;

    logic [15:0] rom [64];
    int errors = 0;
    int checks = 0;

    assign instr = rom[instr_addr];
    always #5 clk = ~clk;

    cpu_v9 dut (
        .clk        (clk),
        .reset      (reset),
        .instr_addr (instr_addr),
        .instr      (instr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .halted     (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(int op, int rd, int ra, int rb);
        return 16'((op << 12) | (rd << 9) | (ra << 6) | (rb << 3));
    endfunction
    function automatic logic [15:0] enc_i(int op, int rd, int imm);
        return 16'((op << 12) | (rd << 9) | (imm & 255));
    endfunction
    function automatic logic [15:0] enc_j(int op, int tgt);
        return 16'((op << 12) | (tgt & 63));
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 16'h0;
    endtask

    // Leaves the bench at a negedge with the core freshly reset, PC=0.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        for (int n = 0; n < budget && !halted; n++) @(negedge clk);
        check({name, "_halt_timeout"}, halted, 1);
    endtask

    typedef struct {
        string name;
        int    op;
        int    a;
        int    b;
        int    res;
        bit    z;
        bit    c;
    } vec_t;

    // Random program run against a plain ISA interpreter.
    task automatic run_random(input int iter);
        int regs[8];
        int in_vals[64];
        int exp_q[$];
        int pc, z, c, ni, op, rd, ra, rb, imm, tgt, res, nxt, got, ni_dut;
        bit done;
        clear_rom();
        for (int a = 0; a < 40; a++) begin
            op = $urandom_range(0, 15);
            if (op == 15) op = 2;
            if (op >= 10 && op <= 13) begin
                tgt = a + 1 + $urandom_range(0, 3);
                if (tgt > 40) tgt = 40;
                rom[a] = enc_j(op, tgt);
            end else if (op == 2) begin
                rom[a] = enc_i(op, $urandom_range(0, 7), $urandom_range(0, 255));
            end else begin
                rom[a] = enc_r(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            end
        end
        rom[40] = enc_j(15, 0);
        for (int i = 0; i < 64; i++) in_vals[i] = $urandom_range(0, 255);

        for (int i = 0; i < 8; i++) regs[i] = 0;
        pc = 0; z = 0; c = 0; ni = 0;
        while ((rom[pc] >> 12) != 15) begin
            op = rom[pc] >> 12; rd = (rom[pc] >> 9) & 7; ra = (rom[pc] >> 6) & 7;
            rb = (rom[pc] >> 3) & 7; imm = rom[pc] & 255; tgt = rom[pc] & 63;
            nxt = pc + 1;
            case (op)
                1: regs[rd] = regs[ra];
                2: regs[rd] = imm;
                3: begin regs[rd] = in_vals[ni]; ni++; end
                4: exp_q.push_back(regs[ra]);
                5, 6, 7, 8, 9: begin
                    case (op)
                        5: begin res = regs[ra] + regs[rb]; c = (res > 255); res = res % 256; end
                        6: begin c = (regs[ra] < regs[rb]); res = (regs[ra] - regs[rb] + 256) % 256; end
                        7: begin res = regs[ra] & regs[rb]; c = 0; end
                        8: begin res = regs[ra] | regs[rb]; c = 0; end
                        default: begin res = regs[ra] ^ regs[rb]; c = 0; end
                    endcase
                    z = (res == 0);
                    regs[rd] = res;
                end
                10: nxt = tgt;
                11: if (z)  nxt = tgt;
                12: if (!z) nxt = tgt;
                13: if (c)  nxt = tgt;
                default: ;
            endcase
            pc = nxt;
        end

        apply_reset();
        got = 0; ni_dut = 0; done = 0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = 8'(in_vals[ni_dut]);
            out_ready = halted ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) ni_dut++;
            if (out_valid && out_ready) begin
                if (got < exp_q.size()) check($sformatf("rand%0d_out%0d", iter, got), out_data, exp_q[got]);
                else check($sformatf("rand%0d_extra_out", iter), 1, 0);
                got++;
            end
            if (halted && !out_valid) done = 1;
            else @(negedge clk);
        end
        check($sformatf("rand%0d_done", iter), done, 1);
        check($sformatf("rand%0d_out_count", iter), got, exp_q.size());
        check($sformatf("rand%0d_halt_pc", iter), instr_addr, pc);
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t vecs[10];
        int subs;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h0;
        clear_rom();

        vecs[0] = '{"add_carry", 5, 200, 100,  44, 0, 1};
        vecs[1] = '{"sub_zero",  6, 100, 100,   0, 1, 0};
        vecs[2] = '{"add_wrap0", 5, 128, 128,   0, 1, 1};
        vecs[3] = '{"sub_borrow",6,   1,   2, 255, 0, 1};
        vecs[4] = '{"and_zero",  7, 240,  15,   0, 1, 0};
        vecs[5] = '{"or_full",   8, 240,  15, 255, 0, 0};
        vecs[6] = '{"xor_self",  9, 170, 170,   0, 1, 0};
        vecs[7] = '{"add_small", 5,   1,   2,   3, 0, 0};
        vecs[8] = '{"sub_plain", 6,   5,   3,   2, 0, 0};
        vecs[9] = '{"mov",       1,  77,   9,  77, 0, 0};

        // Reset then NOP stream: PC wraps, no port activity.
        apply_reset();
        for (int i = 0; i < 66; i++) begin
            check($sformatf("nop_pc%0d", i), instr_addr, i % 64);
            check($sformatf("nop_idle%0d", i), {out_valid, in_ready, halted}, 0);
            @(negedge clk);
        end

        // Flag outcome is encoded in which HALT address the program lands on.
        for (int v = 0; v < 10; v++) begin
            clear_rom();
            rom[0]  = enc_i(2, 1, vecs[v].a);
            rom[1]  = enc_i(2, 2, vecs[v].b);
            rom[2]  = enc_r(vecs[v].op, 3, 1, 2);
            rom[3]  = enc_r(4, 0, 3, 0);
            rom[4]  = enc_j(13, 8);
            rom[5]  = enc_j(11, 7);
            rom[6]  = enc_j(15, 0);
            rom[7]  = enc_j(15, 0);
            rom[8]  = enc_j(11, 10);
            rom[9]  = enc_j(15, 0);
            rom[10] = enc_j(15, 0);
            out_ready = 1'b1;
            apply_reset();
            wait_halt(vecs[v].name, 40);
            check({vecs[v].name, "_data"}, out_data, vecs[v].res);
            check({vecs[v].name, "_flags_pc"}, instr_addr,
                  vecs[v].c ? (vecs[v].z ? 10 : 9) : (vecs[v].z ? 7 : 6));
        end

        // IN stall then transfer.
        clear_rom();
        rom[0] = enc_r(3, 5, 0, 0);
        rom[1] = enc_r(4, 0, 5, 0);
        rom[2] = enc_j(15, 0);
        out_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            check("in_stall_pc", instr_addr, 0);
            check("in_stall_ready", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        check("in_xfer_pc", instr_addr, 1);
        check("in_xfer_ready", in_ready, 0);
        @(negedge clk);
        check("in_out_valid", out_valid, 1);
        check("in_out_data", out_data, 8'h5A);

        // Back-to-back OUTs under backpressure, then reset while halted+pending.
        clear_rom();
        rom[0] = enc_i(2, 1, 11);
        rom[1] = enc_i(2, 2, 22);
        rom[2] = enc_r(4, 0, 1, 0);
        rom[3] = enc_r(4, 0, 2, 0);
        rom[4] = enc_j(15, 0);
        out_ready = 1'b0;
        apply_reset();
        repeat (3) @(negedge clk);
        check("b2b_first_valid", out_valid, 1);
        check("b2b_first_data", out_data, 11);
        repeat (2) @(negedge clk);
        check("b2b_stall_pc", instr_addr, 3);
        check("b2b_stall_data", out_data, 11);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_second_data", out_data, 22);
        check("b2b_second_valid", out_valid, 1);
        check("b2b_second_pc", instr_addr, 4);
        @(negedge clk);
        check("b2b_halted", halted, 1);
        check("b2b_pending_valid", out_valid, 1);
        reset = 1'b1;
        rom[0] = enc_r(4, 0, 1, 0);
        rom[1] = enc_j(15, 0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_halt_pc", instr_addr, 0);
        check("rst_halt_valid", out_valid, 0);
        check("rst_halt_halted", halted, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_halt_reg_valid", out_valid, 1);
        check("rst_halt_reg_zero", out_data, 0);

        // Reset during an IN stall.
        clear_rom();
        rom[0] = enc_i(2, 1, 9);
        rom[1] = enc_r(3, 2, 0, 0);
        rom[2] = enc_j(15, 0);
        apply_reset();
        repeat (2) @(negedge clk);
        check("rst_in_stall_pc", instr_addr, 1);
        check("rst_in_stall_ready", in_ready, 1);
        reset = 1'b1;
        rom[0] = enc_r(4, 0, 1, 0);
        rom[1] = enc_j(15, 0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_pc", instr_addr, 0);
        check("rst_in_flags", {in_ready, halted, out_valid}, 0);
        @(negedge clk);
        check("rst_in_reg_zero", out_data, 0);
        check("rst_in_reg_valid", out_valid, 1);

        // Countdown loop.
        clear_rom();
        rom[0] = enc_i(2, 1, 3);
        rom[1] = enc_i(2, 2, 1);
        rom[2] = enc_r(6, 1, 1, 2);
        rom[3] = enc_j(12, 2);
        rom[4] = enc_j(15, 0);
        apply_reset();
        subs = 0;
        for (int n = 0; n < 40 && !halted; n++) begin
            if (instr_addr == 2) subs++;
            @(negedge clk);
        end
        check("loop_halted", halted, 1);
        check("loop_sub_count", subs, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("loop_frozen_pc", instr_addr, 4);
            check("loop_stay_halted", halted, 1);
        end

        for (int r = 0; r < 4; r++) run_random(r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_v9.md
Name: cpu_v9

Overview:
- Next-generation parametrised accumulator-less register CPU for the course datapath.
- Wider ISA, 2^REG_ADDR_WIDTH registers, Z/C flags, conditional jumps and HALT.
- valid/ready handshakes on the input and output ports replace edge-detect waiting.
- Program ROM is external: the core drives instr_addr and samples instr combinationally in the same cycle.

Parameters:
BUS_WIDTH, 8, datapath/register/port width
REG_ADDR_WIDTH, 3, register-address bits (8 registers)
INSTR_ADDR_WIDTH, 6, PC width (64-word program space)
INSTR_WIDTH, 16, instruction width; must satisfy >= 4+REG_ADDR_WIDTH+BUS_WIDTH and >= 4+3*REG_ADDR_WIDTH, and INSTR_ADDR_WIDTH <= INSTR_WIDTH-4

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-high reset
instr_addr  output  INSTR_ADDR_WIDTH  current PC to program ROM
instr  input  INSTR_WIDTH  instruction at instr_addr (combinational ROM)
in_data  input  BUS_WIDTH  input port data
in_valid  input  1  in_data valid
in_ready  output  1  core accepts in_data this cycle
out_data  output  BUS_WIDTH  registered output port data
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
halted  output  1  core in HALT state

Behaviour:
- Instruction fields, packed from MSB:
  - op = top 4 bits
  - rd = next REG_ADDR_WIDTH bits
  - ra = next REG_ADDR_WIDTH bits
  - rb = next REG_ADDR_WIDTH bits
  - imm = low BUS_WIDTH bits
  - target = low INSTR_ADDR_WIDTH bits
- Opcodes:
  - 0 NOP
  - 1 MOV rd<=ra
  - 2 LDI rd<=imm
  - 3 IN rd<=in_data
  - 4 OUT out<=ra
  - 5 ADD rd<=ra+rb
  - 6 SUB rd<=ra-rb
  - 7 AND
  - 8 OR
  - 9 XOR
  - 10 JMP
  - 11 JZ
  - 12 JNZ
  - 13 JC
  - 14 reserved (executes as NOP)
  - 15 HALT
- FSM has two states, RUN and HALT.
  - RUN executes one instruction per cycle unless stalled.
  - HALT holds PC, register file, flags and out_data; only reset leaves HALT. halted=1 in HALT.
- Reset:
  - PC=0, all registers=0, Z=C=0, out_data=0, out_valid=0, halted=0, state=RUN.
  - Reset takes priority over every event, including a pending IN/OUT stall.
- PC update:
  - Default PC+1, wrapping modulo 2^INSTR_ADDR_WIDTH.
  - Taken jump loads target.
  - A stalled cycle holds PC.
- Register writes: single write port, committed at the clock edge of the executing cycle. Reads are combinational, so a following instruction sees the new value with no hazard.
- Flags:
  - ADD/SUB/AND/OR/XOR set Z=(result==0).
  - ADD sets C=carry-out. SUB sets C=borrow (ra<rb unsigned). Logic ops clear C.
  - All other opcodes leave the flags unchanged.
  - Results truncate to BUS_WIDTH.
- Jumps: JZ/JNZ/JC test the flags as registered before the jump executes.
- IN:
  - in_ready=1 combinationally only while state=RUN and op=IN.
  - Transfer occurs when in_valid & in_ready: rd written, PC advances.
  - Otherwise the core stalls. in_ready=0 for all other opcodes.
- OUT:
  - If out_valid=0, or out_ready=1 this cycle, out_data<=ra, out_valid<=1 and PC advances (no bubble).
  - Otherwise the core stalls.
  - out_valid clears on out_valid & out_ready when no new OUT loads.
  - out_data is stable while out_valid & ~out_ready.
- HALT entry: out_valid/out_data continue their handshake while halted, so a pending output still drains.
- Writing a register that is also a source (e.g. ADD r1,r1,r2) uses the old value.

Decomposition:
- Package cpu_v9_pkg holds:
  - the opcode enum (4-bit)
  - state enum {RUN, HALT}
  - the field-offset localparams, as functions of the parameters
- Sub-module register_file_v2: parametrised width and depth, one write port, two combinational read ports, synchronous reset to 0.
- ALU, flags, PC, FSM and port handshakes stay in cpu_v9.

Test Plan:
- Reset then NOPs: instr_addr counts 0,1,2…63,0 (wrap); out_valid=0, halted=0, in_ready=0 throughout.
- LDI r1,200; LDI r2,100; ADD r3,r1,r2; OUT r3 → out_data=44, C=1, Z=0. Then SUB r4,r2,r2; OUT r4 → out_data=0, Z=1, C=0.
- IN r5 with in_valid low 3 cycles → PC held, in_ready=1. Then in_valid=1, in_data=0x5A → r5=0x5A, PC+1 next cycle.
- Two OUTs back-to-back with out_ready=0 → second OUT stalls, out_data stays at the first value. out_ready=1 for one cycle → second value loads the same edge, no bubble.
- Countdown loop LDI r1,3; LDI r2,1; SUB r1,r1,r2; JNZ 2; HALT → SUB executes 3 times, halted=1. PC is frozen at the HALT address and stays there 10 cycles.
- Reset asserted mid-IN-stall and while halted with out_valid=1 → next cycle PC=0, out_valid=0, halted=0, registers 0.
